// File: rtl/param_reg_file_pkg.sv
// Shared definitions for the parametrised R/T register file.
// Function codes and read-select width helper.
package param_reg_file_pkg;

    localparam logic [2:0] FS_CLR  = 3'b000;
    localparam logic [2:0] FS_LOAD = 3'b001;
    localparam logic [2:0] FS_DEC  = 3'b010;
    localparam logic [2:0] FS_INC  = 3'b011;
    localparam logic [2:0] FS_SHL  = 3'b100;
    localparam logic [2:0] FS_SHR  = 3'b101;
    localparam logic [2:0] FS_ROL  = 3'b110;
    localparam logic [2:0] FS_HOLD = 3'b111;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_reg_file_rf_cell.sv
// One register of the file plus its sticky limit flag.
// Applies the shared function code when enabled.
module rf_cell
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] Input,
    output logic [WIDTH-1:0] Q,
    output logic             Limit
);

    localparam logic SAT = (SATURATE != 0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q     <= '0;
            Limit <= 1'b0;
        end else if (En) begin
            case (FunSel)
                FS_CLR: begin
                    Q     <= '0;
                    Limit <= 1'b0;
                end
                FS_LOAD: begin
                    Q     <= Input;
                    Limit <= 1'b0;
                end
                FS_DEC: begin
                    if (Q == '0) begin
                        Limit <= 1'b1;
                        Q     <= SAT ? Q : Q - WIDTH'(1);
                    end else begin
                        Q <= Q - WIDTH'(1);
                    end
                end
                FS_INC: begin
                    if (Q == '1) begin
                        Limit <= 1'b1;
                        Q     <= SAT ? Q : Q + WIDTH'(1);
                    end else begin
                        Q <= Q + WIDTH'(1);
                    end
                end
                FS_SHL:  Q <= {Q[WIDTH-2:0], 1'b0};
                FS_SHR:  Q <= {1'b0, Q[WIDTH-1:1]};
                FS_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// NUM_T temporary + NUM_R general registers sharing one function code.
// Read index: T1..Tn first, then R1..Rn; out-of-range reads give zero.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_R    = 4,
    parameter int NUM_T    = 4,
    parameter int SATURATE = 0,
    localparam int N       = NUM_T + NUM_R,
    localparam int SEL_W   = sel_w(NUM_T + NUM_R)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Input,
    input  logic [2:0]       FunSel,
    input  logic [NUM_R-1:0] RSel,
    input  logic [NUM_T-1:0] TSel,
    input  logic [SEL_W-1:0] O1Sel,
    input  logic [SEL_W-1:0] O2Sel,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2,
    output logic [N-1:0]     Limit
);

    logic [WIDTH-1:0] q [N];
    logic [N-1:0]     en;

    // Select vectors are MSB-first: bit [n-1] is register 1.
    for (genvar i = 0; i < N; i++) begin : g_cell
        if (i < NUM_T) begin : g_t
            assign en[i] = TSel[NUM_T-1-i];
        end else begin : g_r
            assign en[i] = RSel[NUM_R-1-(i-NUM_T)];
        end

        rf_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .En     (en[i]),
            .FunSel (FunSel),
            .Input  (Input),
            .Q      (q[i]),
            .Limit  (Limit[i])
        );
    end

    always_comb begin
        Output1 = '0;
        Output2 = '0;
        for (int i = 0; i < N; i++) begin
            if (O1Sel == SEL_W'(i)) Output1 = q[i];
            if (O2Sel == SEL_W'(i)) Output2 = q[i];
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench: default file (wrap), saturating copy, and a 12-bit 3T/2R file.
// Vector table, same-cycle/reset sequences, then random vs. model.
module tb_param_reg_file;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Input = '0;
    logic [2:0] FunSel = 3'b111;
    logic [3:0] RSel = '0;
    logic [3:0] TSel = '0;
    logic [2:0] O1Sel = '0;
    logic [2:0] O2Sel = '0;
    logic [7:0] a_out1, a_out2, b_out1, b_out2;
    logic [7:0] a_lim, b_lim;

    logic        c_rst = 1'b1;
    logic [11:0] c_in = '0;
    logic [2:0]  c_fs = 3'b111;
    logic [1:0]  c_rsel = '0;
    logic [2:0]  c_tsel = '0;
    logic [2:0]  c_o1 = '0;
    logic [2:0]  c_o2 = '0;
    logic [11:0] c_out1, c_out2;
    logic [4:0]  c_lim;

    int checks = 0;
    int errors = 0;

    int ma [8];
    int mb [8];
    bit la [8];
    bit lb [8];

    always #20 Clock = ~Clock;

    param_reg_file #(.WIDTH(8), .NUM_R(4), .NUM_T(4), .SATURATE(0)) u_a (
        .Clock(Clock), .Reset(Reset), .Input(Input), .FunSel(FunSel),
        .RSel(RSel), .TSel(TSel), .O1Sel(O1Sel), .O2Sel(O2Sel),
        .Output1(a_out1), .Output2(a_out2), .Limit(a_lim)
    );

    param_reg_file #(.WIDTH(8), .NUM_R(4), .NUM_T(4), .SATURATE(1)) u_b (
        .Clock(Clock), .Reset(Reset), .Input(Input), .FunSel(FunSel),
        .RSel(RSel), .TSel(TSel), .O1Sel(O1Sel), .O2Sel(O2Sel),
        .Output1(b_out1), .Output2(b_out2), .Limit(b_lim)
    );

    param_reg_file #(.WIDTH(12), .NUM_R(2), .NUM_T(3), .SATURATE(0)) u_c (
        .Clock(Clock), .Reset(c_rst), .Input(c_in), .FunSel(c_fs),
        .RSel(c_rsel), .TSel(c_tsel), .O1Sel(c_o1), .O2Sel(c_o2),
        .Output1(c_out1), .Output2(c_out2), .Limit(c_lim)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step_reg(inout int v, inout bit l, input logic [2:0] fs,
                            input int din, input int w, input bit sat);
        int m;
        m = (1 << w) - 1;
        case (fs)
            3'd0: begin v = 0; l = 0; end
            3'd1: begin v = din & m; l = 0; end
            3'd2: begin
                if (v == 0) begin l = 1; v = sat ? 0 : m; end
                else v = v - 1;
            end
            3'd3: begin
                if (v == m) begin l = 1; v = sat ? m : 0; end
                else v = v + 1;
            end
            3'd4: v = (v * 2) & m;
            3'd5: v = v / 2;
            3'd6: v = ((v * 2) & m) | (v >> (w - 1));
            default: ;
        endcase
    endtask

    task automatic model_cycle(input bit rst, input logic [2:0] fs, input int din,
                               input logic [3:0] rs, input logic [3:0] ts);
        bit sel;
        for (int i = 0; i < 8; i++) begin
            if (rst) begin
                ma[i] = 0; mb[i] = 0; la[i] = 0; lb[i] = 0;
            end else begin
                sel = (i < 4) ? ts[3-i] : rs[3-(i-4)];
                if (sel) begin
                    step_reg(ma[i], la[i], fs, din, 8, 1'b0);
                    step_reg(mb[i], lb[i], fs, din, 8, 1'b1);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] ela, elb;
        for (int i = 0; i < 8; i++) begin
            O1Sel = 3'(i);
            O2Sel = 3'(7 - i);
            #1;
            chk($sformatf("a_o1[%0d]", i), int'(a_out1), ma[i]);
            chk($sformatf("a_o2[%0d]", 7 - i), int'(a_out2), ma[7-i]);
            chk($sformatf("b_o1[%0d]", i), int'(b_out1), mb[i]);
            ela[i] = la[i];
            elb[i] = lb[i];
        end
        chk("a_limit", int'(a_lim), int'(ela));
        chk("b_limit", int'(b_lim), int'(elb));
    endtask

    task automatic do_cycle(input bit rst, input logic [2:0] fs, input logic [7:0] din,
                            input logic [3:0] rs, input logic [3:0] ts);
        Reset = rst; FunSel = fs; Input = din; RSel = rs; TSel = ts;
        @(posedge Clock);
        model_cycle(rst, fs, int'(din), rs, ts);
        #2;
        check_all();
    endtask

    typedef struct {
        logic [2:0] fs;
        logic [7:0] din;
        logic [3:0] rs;
        logic [3:0] ts;
        logic [2:0] o1;
        logic [2:0] o2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] elim;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{3'b001, 8'hA5, 4'b1001, 4'b0000, 3'd4, 3'd7, 8'hA5, 8'hA5, 8'h00};
        vt[1]  = '{3'b001, 8'hFF, 4'b0100, 4'b0000, 3'd5, 3'd4, 8'hFF, 8'hA5, 8'h00};
        vt[2]  = '{3'b011, 8'h00, 4'b0100, 4'b0000, 3'd5, 3'd6, 8'h00, 8'h00, 8'h20};
        vt[3]  = '{3'b001, 8'h10, 4'b0100, 4'b0000, 3'd5, 3'd4, 8'h10, 8'hA5, 8'h00};
        vt[4]  = '{3'b001, 8'h81, 4'b0000, 4'b1000, 3'd0, 3'd5, 8'h81, 8'h10, 8'h00};
        vt[5]  = '{3'b100, 8'h00, 4'b0000, 4'b1000, 3'd0, 3'd1, 8'h02, 8'h00, 8'h00};
        vt[6]  = '{3'b001, 8'h81, 4'b0000, 4'b1000, 3'd0, 3'd1, 8'h81, 8'h00, 8'h00};
        vt[7]  = '{3'b101, 8'h00, 4'b0000, 4'b1000, 3'd0, 3'd1, 8'h40, 8'h00, 8'h00};
        vt[8]  = '{3'b001, 8'h81, 4'b0000, 4'b1000, 3'd0, 3'd1, 8'h81, 8'h00, 8'h00};
        vt[9]  = '{3'b110, 8'h00, 4'b0000, 4'b1000, 3'd0, 3'd1, 8'h03, 8'h00, 8'h00};
        vt[10] = '{3'b001, 8'h05, 4'b0000, 4'b0010, 3'd2, 3'd0, 8'h05, 8'h03, 8'h00};
        vt[11] = '{3'b111, 8'h77, 4'b1111, 4'b1111, 3'd2, 3'd0, 8'h05, 8'h03, 8'h00};
        vt[12] = '{3'b010, 8'h00, 4'b0001, 4'b0000, 3'd7, 3'd5, 8'hA4, 8'h10, 8'h00};
        vt[13] = '{3'b000, 8'h00, 4'b1111, 4'b1111, 3'd4, 3'd0, 8'h00, 8'h00, 8'h00};
        vt[14] = '{3'b010, 8'h00, 4'b0000, 4'b0001, 3'd3, 3'd0, 8'hFF, 8'h00, 8'h08};

        // Reset with an active function code: everything reads zero.
        do_cycle(1'b1, 3'b001, 8'h5A, 4'b1111, 4'b1111);

        for (int k = 0; k < 15; k++) begin
            do_cycle(1'b0, vt[k].fs, vt[k].din, vt[k].rs, vt[k].ts);
            O1Sel = vt[k].o1;
            O2Sel = vt[k].o2;
            #1;
            chk($sformatf("vec%0d_o1", k), int'(a_out1), int'(vt[k].e1));
            chk($sformatf("vec%0d_o2", k), int'(a_out2), int'(vt[k].e2));
            chk($sformatf("vec%0d_lim", k), int'(a_lim), int'(vt[k].elim));
        end

        // Saturating copy: increment of FF holds and sets the flag.
        do_cycle(1'b0, 3'b001, 8'hFF, 4'b0100, 4'b0000);
        do_cycle(1'b0, 3'b011, 8'h00, 4'b0100, 4'b0000);
        O1Sel = 3'd5;
        #1;
        chk("sat_inc_val", int'(b_out1), 8'hFF);
        chk("sat_inc_lim", int'(b_lim[5]), 1);
        chk("wrap_inc_val", int'(a_out1), 8'h00);

        // Same-cycle read returns the old value; new value after the edge.
        do_cycle(1'b0, 3'b001, 8'h05, 4'b0000, 4'b0010);
        Reset = 1'b0; FunSel = 3'b011; RSel = '0; TSel = 4'b0010; O1Sel = 3'd2;
        #1;
        chk("same_cycle_old", int'(a_out1), 8'h05);
        @(posedge Clock);
        model_cycle(1'b0, 3'b011, 0, 4'b0000, 4'b0010);
        #2;
        chk("same_cycle_new", int'(a_out1), 8'h06);
        check_all();

        // Reset in the middle of back-to-back increments.
        do_cycle(1'b0, 3'b011, 8'h00, 4'b1111, 4'b1111);
        do_cycle(1'b0, 3'b011, 8'h00, 4'b1111, 4'b1111);
        do_cycle(1'b1, 3'b011, 8'h00, 4'b1111, 4'b1111);
        chk("midrst_lim", int'(a_lim), 0);
        do_cycle(1'b0, 3'b011, 8'h00, 4'b1111, 4'b1111);
        O1Sel = 3'd6;
        #1;
        chk("after_rst_inc", int'(a_out1), 1);

        for (int k = 0; k < 400; k++) begin
            do_cycle($urandom_range(0, 31) == 0, 3'($urandom_range(0, 7)),
                     8'($urandom), 4'($urandom), 4'($urandom));
        end

        // 12-bit file with 3 T and 2 R registers.
        for (int i = 0; i < 8; i++) begin
            c_o1 = 3'(i);
            #1;
            chk($sformatf("c_rst_o1[%0d]", i), int'(c_out1), 0);
        end
        chk("c_rst_lim", int'(c_lim), 0);
        c_rst = 1'b0; c_fs = 3'b010; c_rsel = 2'b01; c_tsel = '0;
        @(posedge Clock);
        #2;
        c_fs = 3'b111; c_rsel = '0;
        c_o1 = 3'd4; c_o2 = 3'd3;
        #1;
        chk("c_dec_r2", int'(c_out1), 12'hFFF);
        chk("c_r1", int'(c_out2), 0);
        chk("c_lim", int'(c_lim), 5'b10000);
        for (int i = 5; i < 8; i++) begin
            c_o2 = 3'(i);
            #1;
            chk($sformatf("c_oob[%0d]", i), int'(c_out2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
# param_reg_file

Parametrised successor to the datapath's 8-bit R/T register file: NUM_R general registers and NUM_T temporary registers, each WIDTH bits, updated on a single clock edge by a shared function code applied to every register whose select bit is set. Two combinational read ports feed the ALU and address paths. Adds shift/rotate functions, an optional saturating mode and per-register sticky limit flags.

## Interface
- WIDTH, 8, register width in bits (≥2)
- NUM_R, 4, general registers R1..R{NUM_R} (1..16)
- NUM_T, 4, temporary registers T1..T{NUM_T} (1..16)
- SATURATE, 0, 1 = inc/dec clamp at limits; 0 = wrap modulo 2^WIDTH
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; dominates every other input
- Input  in  WIDTH  load data
- FunSel  in  3  function code (see Operation)
- RSel  in  NUM_R  write enables; RSel[NUM_R-1]=R1 … RSel[0]=R{NUM_R}
- TSel  in  NUM_T  write enables; TSel[NUM_T-1]=T1 … TSel[0]=T{NUM_T}
- O1Sel  in  SEL_W  read port 1 index, SEL_W = clog2(NUM_T+NUM_R)
- O2Sel  in  SEL_W  read port 2 index
- Output1  out  WIDTH  read port 1 data
- Output2  out  WIDTH  read port 2 data
- Limit  out  NUM_T+NUM_R  sticky flag per register, bit i matches read index i

## Operation
- Read index map: 0..NUM_T-1 = T1..T{NUM_T}; NUM_T..NUM_T+NUM_R-1 = R1..R{NUM_R}; index ≥ NUM_T+NUM_R returns all zeros.
- Reads combinational from current register contents; no write-to-read bypass. Both ports may select the same register.
- FunSel codes, applied identically to every selected register on the edge: 000 clear; 001 load Input; 010 decrement; 011 increment; 100 shift left, LSB←0; 101 logical shift right, MSB←0; 110 rotate left by 1; 111 hold.
- Unselected registers hold. RSel=TSel=0 → no state change regardless of FunSel.
- Width rule: all arithmetic modulo 2^WIDTH when SATURATE=0. SATURATE=1: increment at all-ones holds all-ones; decrement at zero holds zero.
- Limit[i] set on increment of all-ones or decrement of zero (either SATURATE mode). Cleared by clear or load of that register. Shifts, rotates and hold leave it unchanged. Set and clear cannot coincide (one function per cycle).
- Reset: all registers 0, Limit all 0; therefore Output1 = Output2 = 0 after reset.

## Timing
- Write latency 1 cycle: value visible on outputs after the capturing rising edge; same-cycle read returns the old value.
- Limit updates on the same edge as the register.
- Reset asserted mid-sequence: the next edge zeroes everything; FunSel/selects ignored that cycle; operation resumes on the first edge with Reset low.
- No handshakes; every cycle may issue an operation; back-to-back increments advance once per cycle.
- Outputs glitch-free relative to Clock only; selects are expected stable around the edge.

## Structure
- Shared package: FunSel localparams (FS_CLR, FS_LOAD, FS_DEC, FS_INC, FS_SHL, FS_SHR, FS_ROL, FS_HOLD), and a SEL_W helper function.
- Sub-module rf_cell: one WIDTH register plus its Limit bit, ports Clock, Reset, En, FunSel, Input, Q, Limit, parameters WIDTH and SATURATE; instantiated NUM_T+NUM_R times by generate. Top level contains only enable mapping and two read muxes.

## Test plan
- Reset → all Output1/Output2 reads 0 for every index, Limit=0; assert Reset while mid-increments → next edge all zero.
- Defaults; FunSel=001, Input=8'hA5, RSel=4'b1001, TSel=0 → next cycle R1=R4=A5, R2,R3,T* =0; O1Sel=4 returns A5, O2Sel=7 returns A5.
- R2=8'hFF, FunSel=011, RSel=4'b0100 → SATURATE=0: R2=00, Limit[5]=1; SATURATE=1: R2=FF, Limit[5]=1; subsequent load of 8'h10 clears Limit[5].
- T1=8'h81: FunSel=100 → 02; reload 81, FunSel=101 → 40; reload 81, FunSel=110 → 03; Limit[0] unchanged throughout.
- Same-cycle read: T3=05, FunSel=011 with TSel=4'b0010, O1Sel=2 → Output1=05 before edge, 06 after; FunSel=111 with all selects set → no register changes.
- NUM_R=2, NUM_T=3, WIDTH=12: O1Sel=5,6,7 → 0; dec of zero in R2 → 12'hFFF, Limit[4]=1.
